// File: rtl/mac_accum_8lane.sv
// 8-lane saturating group accumulator: sums ACC_LEN beats per lane; result appears one cycle after the last beat.
// in_ready drops while a finished result is held unconsumed; the open partial group then freezes.
module mac_accum_8lane #(
    parameter int ACC_LEN = 8,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      p0,
    input  logic [15:0]      p1,
    input  logic [15:0]      p2,
    input  logic [15:0]      p3,
    input  logic [15:0]      p4,
    input  logic [15:0]      p5,
    input  logic [15:0]      p6,
    input  logic [15:0]      p7,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             acc_clear,
    output logic [ACC_W-1:0] out_acc0,
    output logic [ACC_W-1:0] out_acc1,
    output logic [ACC_W-1:0] out_acc2,
    output logic [ACC_W-1:0] out_acc3,
    output logic [ACC_W-1:0] out_acc4,
    output logic [ACC_W-1:0] out_acc5,
    output logic [ACC_W-1:0] out_acc6,
    output logic [ACC_W-1:0] out_acc7,
    output logic [7:0]       out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam int               LANES    = 8;
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [15:0]      w_p       [LANES];
    logic [ACC_W-1:0] r_acc     [LANES];
    logic [ACC_W-1:0] w_acc_nxt [LANES];
    logic [ACC_W-1:0] r_out_acc [LANES];
    logic [ACC_W:0]   w_sum     [LANES];

    logic [7:0]       r_sat;
    logic [7:0]       w_sat_nxt;
    logic [7:0]       r_out_sat;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;

    assign w_p[0] = p0;
    assign w_p[1] = p1;
    assign w_p[2] = p2;
    assign w_p[3] = p3;
    assign w_p[4] = p4;
    assign w_p[5] = p5;
    assign w_p[6] = p6;
    assign w_p[7] = p7;

    // A pending result blocks new beats unless it is being drained this cycle.
    assign w_in_ready = rst && !acc_clear && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_last     = w_accept && (r_beat_cnt == LAST_CNT);

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign w_sum[g]     = {1'b0, r_acc[g]} + (ACC_W+1)'(w_p[g]);
            assign w_acc_nxt[g] = (r_state == S_IDLE) ? ACC_W'(w_p[g])
                                : (w_sum[g][ACC_W] ? ACC_MAX : w_sum[g][ACC_W-1:0]);
            assign w_sat_nxt[g] = (r_state == S_IDLE) ? 1'b0
                                : (r_sat[g] | w_sum[g][ACC_W]);
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_beat_cnt;
        if (acc_clear) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_accept) begin
            if (w_last) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = S_ACCUM;
                w_cnt_nxt   = r_beat_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_sat       <= '0;
            r_out_sat   <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_acc[i]     <= '0;
                r_out_acc[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_cnt_nxt;

            if (acc_clear) begin
                r_sat <= '0;
                for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
            end else if (w_accept) begin
                r_sat <= w_sat_nxt;
                for (int i = 0; i < LANES; i++) r_acc[i] <= w_acc_nxt[i];
            end

            // A completing group takes priority over draining the old result.
            if (w_last) begin
                r_out_valid <= 1'b1;
                r_out_sat   <= w_sat_nxt;
                for (int i = 0; i < LANES; i++) r_out_acc[i] <= w_acc_nxt[i];
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sat   = r_out_sat;
    assign beat_cnt  = r_beat_cnt;
    assign out_acc0  = r_out_acc[0];
    assign out_acc1  = r_out_acc[1];
    assign out_acc2  = r_out_acc[2];
    assign out_acc3  = r_out_acc[3];
    assign out_acc4  = r_out_acc[4];
    assign out_acc5  = r_out_acc[5];
    assign out_acc6  = r_out_acc[6];
    assign out_acc7  = r_out_acc[7];

endmodule

// File: tb/tb_mac_accum_8lane.sv
// Bench for mac_accum_8lane: three instances (ACC_LEN=4; ACC_W=18/ACC_LEN=5; ACC_LEN=1) share one stimulus.
module tb_mac_accum_8lane;

    logic        clk;
    logic        rst;
    logic [15:0] p [8];
    logic        in_valid;
    logic        acc_clear;
    logic        out_ready;

    logic        rdy4, ovld4;
    logic [23:0] a4 [8];
    logic [7:0]  sat4, cnt4;

    logic        rdys, ovlds;
    logic [17:0] as_ [8];
    logic [7:0]  sats, cnts;

    logic        rdy1, ovld1;
    logic [23:0] a1 [8];
    logic [7:0]  sat1, cnt1;

    int checks = 0;
    int errors = 0;

    mac_accum_8lane #(.ACC_LEN(4), .ACC_W(24), .CNT_W(8)) u_d4 (
        .clk(clk), .rst(rst),
        .p0(p[0]), .p1(p[1]), .p2(p[2]), .p3(p[3]), .p4(p[4]), .p5(p[5]), .p6(p[6]), .p7(p[7]),
        .in_valid(in_valid), .in_ready(rdy4), .acc_clear(acc_clear),
        .out_acc0(a4[0]), .out_acc1(a4[1]), .out_acc2(a4[2]), .out_acc3(a4[3]),
        .out_acc4(a4[4]), .out_acc5(a4[5]), .out_acc6(a4[6]), .out_acc7(a4[7]),
        .out_sat(sat4), .out_valid(ovld4), .out_ready(out_ready), .beat_cnt(cnt4)
    );

    mac_accum_8lane #(.ACC_LEN(5), .ACC_W(18), .CNT_W(8)) u_ds (
        .clk(clk), .rst(rst),
        .p0(p[0]), .p1(p[1]), .p2(p[2]), .p3(p[3]), .p4(p[4]), .p5(p[5]), .p6(p[6]), .p7(p[7]),
        .in_valid(in_valid), .in_ready(rdys), .acc_clear(acc_clear),
        .out_acc0(as_[0]), .out_acc1(as_[1]), .out_acc2(as_[2]), .out_acc3(as_[3]),
        .out_acc4(as_[4]), .out_acc5(as_[5]), .out_acc6(as_[6]), .out_acc7(as_[7]),
        .out_sat(sats), .out_valid(ovlds), .out_ready(out_ready), .beat_cnt(cnts)
    );

    mac_accum_8lane #(.ACC_LEN(1), .ACC_W(24), .CNT_W(8)) u_d1 (
        .clk(clk), .rst(rst),
        .p0(p[0]), .p1(p[1]), .p2(p[2]), .p3(p[3]), .p4(p[4]), .p5(p[5]), .p6(p[6]), .p7(p[7]),
        .in_valid(in_valid), .in_ready(rdy1), .acc_clear(acc_clear),
        .out_acc0(a1[0]), .out_acc1(a1[1]), .out_acc2(a1[2]), .out_acc3(a1[3]),
        .out_acc4(a1[4]), .out_acc5(a1[5]), .out_acc6(a1[6]), .out_acc7(a1[7]),
        .out_sat(sat1), .out_valid(ovld1), .out_ready(out_ready), .beat_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        clr;
        logic        ordy;
        logic [15:0] pv;
        logic        rdy;
        logic [7:0]  cnt;
        logic        ovld;
        logic [23:0] acc0;
        logic [23:0] acc7;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic vld, input logic clr, input logic ordy, input int pv,
                                input logic rdy, input int cnt, input logic ovld,
                                input int a0, input int a7);
        vec_t v;
        v.vld  = vld;
        v.clr  = clr;
        v.ordy = ordy;
        v.pv   = 16'(pv);
        v.rdy  = rdy;
        v.cnt  = 8'(cnt);
        v.ovld = ovld;
        v.acc0 = 24'(a0);
        v.acc7 = 24'(a7);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        acc_clear = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) p[k] = 16'hFFFF;

        // Reset held with valid input present: nothing may be accepted.
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rst_rdy4", rdy4, 0);
            chk("rst_rdys", rdys, 0);
            chk("rst_rdy1", rdy1, 0);
            tick();
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) p[k] = 16'h0;
        tick();
        chk("rst_ovld4", ovld4, 0);
        chk("rst_cnt4", cnt4, 0);
        chk("rst_sat4", sat4, 0);
        chk("rst_ovlds", ovlds, 0);
        chk("rst_ovld1", ovld1, 0);
        for (int k = 0; k < 8; k++) begin
            chk("rst_acc4", a4[k], 0);
            chk("rst_accs", as_[k], 0);
        end

        // Lane k gets pv*(k+1). Columns: vld clr ordy pv | rdy cnt ovld acc0 acc7
        tbl[0]  = mk(1, 0, 1, 100, 1, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 100, 1, 2, 0, 0, 0);
        tbl[2]  = mk(1, 0, 1, 100, 1, 3, 0, 0, 0);
        tbl[3]  = mk(1, 0, 1, 100, 1, 0, 1, 400, 3200);
        tbl[4]  = mk(1, 0, 0, 1,   0, 0, 1, 400, 3200);
        tbl[5]  = mk(1, 0, 0, 1,   0, 0, 1, 400, 3200);
        tbl[6]  = mk(1, 0, 0, 1,   0, 0, 1, 400, 3200);
        tbl[7]  = mk(1, 0, 0, 1,   0, 0, 1, 400, 3200);
        tbl[8]  = mk(1, 0, 0, 1,   0, 0, 1, 400, 3200);
        tbl[9]  = mk(1, 0, 1, 1,   1, 1, 0, 400, 3200);
        tbl[10] = mk(1, 0, 1, 2,   1, 2, 0, 400, 3200);
        tbl[11] = mk(1, 0, 1, 3,   1, 3, 0, 400, 3200);
        tbl[12] = mk(0, 0, 1, 9,   1, 3, 0, 400, 3200);
        tbl[13] = mk(1, 0, 1, 4,   1, 0, 1, 10, 80);
        tbl[14] = mk(1, 0, 1, 1,   1, 1, 0, 10, 80);
        tbl[15] = mk(1, 0, 1, 1,   1, 2, 0, 10, 80);
        tbl[16] = mk(1, 1, 1, 1,   0, 0, 0, 10, 80);
        tbl[17] = mk(1, 0, 1, 1,   1, 1, 0, 10, 80);
        tbl[18] = mk(1, 0, 1, 1,   1, 2, 0, 10, 80);
        tbl[19] = mk(1, 0, 1, 1,   1, 3, 0, 10, 80);
        tbl[20] = mk(1, 0, 1, 1,   1, 0, 1, 4, 32);
        tbl[21] = mk(1, 1, 0, 1,   0, 0, 1, 4, 32);
        tbl[22] = mk(1, 1, 1, 1,   0, 0, 0, 4, 32);

        for (int r = 0; r < 23; r++) begin
            in_valid  = tbl[r].vld;
            acc_clear = tbl[r].clr;
            out_ready = tbl[r].ordy;
            for (int k = 0; k < 8; k++) p[k] = 16'(tbl[r].pv * (k + 1));
            #1;
            chk($sformatf("tbl%0d_rdy", r), rdy4, tbl[r].rdy);
            tick();
            chk($sformatf("tbl%0d_cnt", r), cnt4, tbl[r].cnt);
            chk($sformatf("tbl%0d_ovld", r), ovld4, tbl[r].ovld);
            chk($sformatf("tbl%0d_acc0", r), a4[0], tbl[r].acc0);
            chk($sformatf("tbl%0d_acc7", r), a4[7], tbl[r].acc7);
            chk($sformatf("tbl%0d_sat", r), sat4, 0);
        end

        // Reset in the middle of an open group.
        acc_clear = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) p[k] = 16'd1;
        tick();
        tick();
        chk("mid_cnt4", cnt4, 2);
        chk("mid_ovld1", ovld1, 1);
        rst = 1'b0;
        #1;
        chk("mid_rdy4", rdy4, 0);
        tick();
        chk("mid_rst_cnt4", cnt4, 0);
        chk("mid_rst_ovld4", ovld4, 0);
        chk("mid_rst_acc4", a4[0], 0);
        chk("mid_rst_ovld1", ovld1, 0);
        chk("mid_rst_acc1", a1[0], 0);
        rst = 1'b1;

        // Saturation on ACC_W=18: 5*65025 overflows lane 0 only.
        p[0] = 16'd65025;
        for (int b = 1; b <= 5; b++) begin
            tick();
            chk($sformatf("sat_cnt%0d", b), cnts, (b == 5) ? 0 : b);
            chk($sformatf("sat_ovld%0d", b), ovlds, (b == 5) ? 1 : 0);
        end
        chk("sat_acc0", as_[0], 262143);
        chk("sat_flags", sats, 8'h01);
        for (int k = 1; k < 8; k++) chk($sformatf("sat_acc%0d", k), as_[k], 5);

        // Streaming with ACC_LEN=1.
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        rst      = 1'b1;
        for (int n = 0; n < 16; n++) begin
            in_valid = 1'b1;
            for (int k = 0; k < 8; k++) p[k] = 16'(n + k);
            #1;
            chk($sformatf("str%0d_rdy", n), rdy1, 1);
            tick();
            chk($sformatf("str%0d_ovld", n), ovld1, 1);
            chk($sformatf("str%0d_cnt", n), cnt1, 0);
            chk($sformatf("str%0d_sat", n), sat1, 0);
            for (int k = 0; k < 8; k++) chk($sformatf("str%0d_acc%0d", n, k), a1[k], n + k);
        end
        in_valid = 1'b0;
        tick();
        chk("str_drain_ovld", ovld1, 0);
        chk("str_drain_acc7", a1[7], 22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
